// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared constants, opcode and state encodings for the HI/LO unit
// Purpose: common definitions imported by hilo_ctrl_if, muldiv_iter and hilo_ctrl.
// Ports: none (package).
package hilo_pkg;

  localparam int REG_LENGTH = 32;
  localparam int ITER_COUNT = 32;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  // Magnitude of a possibly-signed operand; unsigned ops pass straight through.
  function automatic logic [REG_LENGTH-1:0] abs_val(input logic [REG_LENGTH-1:0] v,
                                                    input logic                  is_signed);
    abs_val = (is_signed && v[REG_LENGTH-1]) ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/hilo_ctrl_if.sv
// rtl/hilo_ctrl_if.sv - EX-stage to HI/LO controller operation and write-port bundle
// Purpose: groups the op request, flush, stall and HI/LO write-port signals.
// Ports: opValid/opCode/opA/opB/flush (pipeline -> controller);
//        busy/hiWtCe/loWtCe/hiWtData/loWtData/divZero (controller -> pipeline).
interface hilo_ctrl_if;
  import hilo_pkg::*;

  logic                  opValid;
  logic [2:0]            opCode;
  logic [REG_LENGTH-1:0] opA;
  logic [REG_LENGTH-1:0] opB;
  logic                  flush;
  logic                  busy;
  logic                  hiWtCe;
  logic                  loWtCe;
  logic [REG_LENGTH-1:0] hiWtData;
  logic [REG_LENGTH-1:0] loWtData;
  logic                  divZero;

  modport master (
    output opValid, opCode, opA, opB, flush,
    input  busy, hiWtCe, loWtCe, hiWtData, loWtData, divZero
  );

  modport slave (
    input  opValid, opCode, opA, opB, flush,
    output busy, hiWtCe, loWtCe, hiWtData, loWtData, divZero
  );

endinterface

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - 32-bit iterative shift-add multiplier / restoring divider datapath
// Purpose: one multiply or divide step per asserted step; hi_next/lo_next show the
//          result of the step being taken this cycle so the caller can register it.
// Ports: clk, rst (sync, active-high); load, step, is_div controls; a, b unsigned
//        magnitudes; hi_next, lo_next step result (product {hi,lo} or {rem,quo}).
module muldiv_iter
  import hilo_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  step,
  input  logic                  is_div,
  input  logic [REG_LENGTH-1:0] a,
  input  logic [REG_LENGTH-1:0] b,
  output logic [REG_LENGTH-1:0] hi_next,
  output logic [REG_LENGTH-1:0] lo_next
);

  // Multiply: hi accumulates, lo holds the multiplier and collects product bits.
  // Divide:   hi is the partial remainder, lo shifts the dividend out and quotient in.
  logic [REG_LENGTH-1:0] hi_r, lo_r, m_r;
  logic [REG_LENGTH:0]   sum, trial, diff;

  always_comb begin
    sum     = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : '0);
    trial   = {hi_r, lo_r[REG_LENGTH-1]};
    diff    = trial - {1'b0, m_r};
    hi_next = hi_r;
    lo_next = lo_r;
    if (is_div) begin
      // Restoring step: keep the subtraction only when it did not borrow.
      if (!diff[REG_LENGTH]) begin
        hi_next = diff[REG_LENGTH-1:0];
        lo_next = {lo_r[REG_LENGTH-2:0], 1'b1};
      end else begin
        hi_next = trial[REG_LENGTH-1:0];
        lo_next = {lo_r[REG_LENGTH-2:0], 1'b0};
      end
    end else begin
      hi_next = sum[REG_LENGTH:1];
      lo_next = {sum[0], lo_r[REG_LENGTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_r <= '0;
      lo_r <= '0;
      m_r  <= '0;
    end else if (load) begin
      hi_r <= '0;
      lo_r <= is_div ? a : b;
      m_r  <= is_div ? b : a;
    end else if (step) begin
      hi_r <= hi_next;
      lo_r <= lo_next;
    end
  end

endmodule

// File: rtl/hilo_ctrl.sv
// rtl/hilo_ctrl.sv - HI/LO multiply/divide/move controller with registered write port
// Purpose: accepts EX-stage HI/LO ops, sequences the 32-step datapath, applies sign
//          correction and drives the HI/LO register-file write port.
// Ports: clk, rst (sync, active-high); bus (hilo_ctrl_if.slave) op request in,
//        busy/write port/divZero out.
module hilo_ctrl
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  hilo_ctrl_if.slave  bus
);

  state_e                  state, state_n;
  logic [5:0]              cnt, cnt_n;
  logic                    neg_q, neg_r, neg_q_n, neg_r_n;
  logic                    hi_we, lo_we, dz, hi_we_n, lo_we_n, dz_n;
  logic [REG_LENGTH-1:0]   hi_d, lo_d, hi_d_n, lo_d_n;
  logic [REG_LENGTH-1:0]   hi_next, lo_next;
  logic [2*REG_LENGTH-1:0] prod, prod_c;
  logic                    accept, is_signed, long_op, sign_a, sign_b, ld, step, dp_div;
  op_e                     op;

  muldiv_iter u_iter (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .step    (step),
    .is_div  (dp_div),
    .a       (abs_val(bus.opA, is_signed)),
    .b       (abs_val(bus.opB, is_signed)),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      hi_we <= 1'b0;
      lo_we <= 1'b0;
      dz    <= 1'b0;
      hi_d  <= '0;
      lo_d  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      hi_we <= hi_we_n;
      lo_we <= lo_we_n;
      dz    <= dz_n;
      hi_d  <= hi_d_n;
      lo_d  <= lo_d_n;
    end
  end

  always_comb begin
    op        = op_e'(bus.opCode);
    accept    = (state == S_IDLE) && bus.opValid && !bus.flush;
    is_signed = (op == OP_MULT) || (op == OP_DIV);
    long_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    sign_a    = is_signed && bus.opA[REG_LENGTH-1];
    sign_b    = is_signed && bus.opB[REG_LENGTH-1];
    bus.busy  = (state != S_IDLE) || (accept && long_op);
    // The datapath mode comes from the opcode while loading, from the state while stepping.
    dp_div    = (state == S_DIV) || ((state == S_IDLE) && ((op == OP_DIV) || (op == OP_DIVU)));
    step      = (state == S_MUL) || (state == S_DIV);
    prod      = {hi_next, lo_next};
    prod_c    = neg_q ? (~prod + 1'b1) : prod;

    state_n = state;
    cnt_n   = cnt;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    ld      = 1'b0;
    hi_we_n = 1'b0;
    lo_we_n = 1'b0;
    dz_n    = 1'b0;
    hi_d_n  = '0;
    lo_d_n  = '0;

    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_n = S_MUL;
              cnt_n   = '0;
              ld      = 1'b1;
              neg_q_n = sign_a ^ sign_b;
              neg_r_n = sign_a ^ sign_b;
            end
            OP_DIV, OP_DIVU: begin
              if (bus.opB == '0) begin
                dz_n = 1'b1;
              end else begin
                state_n = S_DIV;
                cnt_n   = '0;
                ld      = 1'b1;
                neg_q_n = sign_a ^ sign_b;
                neg_r_n = sign_a;
              end
            end
            OP_MTHI: begin
              hi_we_n = 1'b1;
              hi_d_n  = bus.opA;
            end
            OP_MTLO: begin
              lo_we_n = 1'b1;
              lo_d_n  = bus.opA;
            end
            default: ;
          endcase
        end
      end
      S_MUL, S_DIV: begin
        if (cnt == 6'(ITER_COUNT - 1)) begin
          // Last step: register the sign-corrected result straight from the step output.
          state_n = S_WB;
          cnt_n   = '0;
          hi_we_n = 1'b1;
          lo_we_n = 1'b1;
          if (state == S_MUL) begin
            hi_d_n = prod_c[2*REG_LENGTH-1:REG_LENGTH];
            lo_d_n = prod_c[REG_LENGTH-1:0];
          end else begin
            hi_d_n = neg_r ? (~hi_next + 1'b1) : hi_next;
            lo_d_n = neg_q ? (~lo_next + 1'b1) : lo_next;
          end
        end else begin
          cnt_n = cnt + 6'd1;
        end
      end
      S_WB: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (bus.flush) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      ld      = 1'b0;
      hi_we_n = 1'b0;
      lo_we_n = 1'b0;
      dz_n    = 1'b0;
      hi_d_n  = '0;
      lo_d_n  = '0;
    end
  end

  assign bus.hiWtCe   = hi_we;
  assign bus.loWtCe   = lo_we;
  assign bus.hiWtData = hi_d;
  assign bus.loWtData = lo_d;
  assign bus.divZero  = dz;

endmodule
